pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the ID/EX pipeline register and the front end (PC, IF/ID) of the 5-stage core.
//  Detects load-use hazards, squashes wrong-path instructions on taken branches and holds the
//  pipe while the multi-cycle multiply/divide unit (MDU) in EX is busy.
//  Drives write enables and bubble/flush strobes. Bubble = ID/EX WB/M/EX fields loaded as zero.
// PARAMETERS
//  MDU_LAT   4  total MDU cycles, start cycle included; legal range 2..15
//  INIT_CYC  3  cycles after reset during which the pipe is filled with bubbles; legal range 1..15
//  CNT_W     16 width of performance counters (HAZ_PERF_CNT_EN only)
// PORTS
//  clk             in   1  core clock, rising edge
//  rst_n           in   1  asynchronous, active-low reset
//  if_id_rs        in   5  rs field of the instruction in ID
//  if_id_rt        in   5  rt field of the instruction in ID
//  if_id_uses_rt   in   1  instruction in ID reads rt as a source
//  id_ex_mem_read  in   1  instruction in EX is a load
//  id_ex_rt        in   5  destination rt of the instruction in EX
//  branch_taken    in   1  branch/jump resolved taken in EX this cycle
//  mdu_start       in   1  mult/div in EX starts this cycle (1-cycle pulse)
//  pc_write        out  1  PC update enable
//  if_id_write     out  1  IF/ID register load enable
//  if_id_flush     out  1  IF/ID loads a NOP
//  id_ex_write     out  1  ID/EX register load enable
//  id_ex_bubble    out  1  ID/EX control fields forced to zero
//  mdu_busy        out  1  MDU sequence in progress
//  stall_cnt       out  CNT_W  stall cycles counted (HAZ_PERF_CNT_EN only)
//  flush_cnt       out  CNT_W  taken-branch flushes counted (HAZ_PERF_CNT_EN only)
// BEHAVIOUR
//  FSM states: INIT, RUN, MDU_BUSY. A 4-bit down-counter (cnt) is shared by INIT and MDU_BUSY.
//  Reset (async assert, sync release) sets state=INIT and cnt=INIT_CYC-1.
//  INIT outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_write=1, id_ex_bubble=1, mdu_busy=0.
//  INIT: cnt decrements each cycle. At cnt==0, next state is RUN. INIT lasts exactly INIT_CYC cycles.
//  INIT ignores all inputs.
//  RUN priority and outputs (Mealy, same cycle as the input):
//   1. branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. Stays in RUN.
//      A simultaneous mdu_start is dropped (wrong-path MDU op is squashed).
//   2. mdu_start: pc_write=0, if_id_write=0, id_ex_write=0, mdu_busy=1. Next state MDU_BUSY,
//      cnt=MDU_LAT-2.
//   3. load_use: id_ex_mem_read && id_ex_rt!=0 &&
//      (id_ex_rt==if_id_rs || (if_id_uses_rt && id_ex_rt==if_id_rt)).
//      Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1. Exactly one stall cycle per load.
//   4. Otherwise: pc_write=1, if_id_write=1, id_ex_write=1, flush=0, bubble=0.
//  MDU_BUSY outputs: pc_write=0, if_id_write=0, id_ex_write=0, mdu_busy=1.
//   cnt decrements each cycle. At cnt==0, next state is RUN.
//   Total front-end freeze = MDU_LAT cycles.
//   branch_taken, mdu_start and load_use are ignored; EX holds the MDU op, so branch_taken
//   cannot legally occur. A simulation assertion fires if it does.
//  Reset asserted mid-MDU or mid-INIT: immediately returns to INIT with INIT outputs.
//  id_ex_rt==0 never causes a stall ($zero is never a hazard).
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - stall_cnt increments on every cycle with pc_write==0 while state!=INIT.
//   - flush_cnt increments on every RUN cycle with branch_taken.
//   - Both counters saturate at all-ones and reset to 0.
//  HAZ_PERF_CNT_EN undefined: stall_cnt and flush_cnt ports are absent and no counter logic exists.
// STRUCTURE
//  hazard_pkg: state enum (INIT/RUN/MDU_BUSY, 2 bits), REG_IDX_W=5, ZERO_REG=5'd0, CNT4_W=4.
//  Sub-module hazard_down_counter: load, load value, decrement enable, zero flag.
//   One instance, shared by INIT and MDU_BUSY.
//  Load-use compare and output decode are inline combinational logic.
// TESTING
//  1. Release rst_n. Required: pc_write=0, if_id_flush=1, id_ex_bubble=1 for exactly 3 cycles,
//     then RUN with all enables=1.
//  2. RUN, id_ex_mem_read=1, id_ex_rt=5'd8, if_id_rs=5'd8.
//     Required: one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1.
//     Repeat with id_ex_rt=0: no stall.
//  3. if_id_uses_rt=0, if_id_rt=5'd8, if_id_rs=5'd3, load with rt=8. Required: no stall.
//     Set if_id_uses_rt=1: one-cycle stall.
//  4. mdu_start pulse in RUN. Required: pc_write=0 and mdu_busy=1 for exactly 4 cycles,
//     then RUN. A load-use during the busy window adds no extra stall.
//  5. branch_taken and mdu_start in the same cycle. Required: if_id_flush=1, id_ex_bubble=1,
//     mdu_busy stays 0, state stays RUN.
//  6. rst_n pulled low on the 2nd MDU_BUSY cycle. Required: immediate INIT outputs, mdu_busy=0.
//     With HAZ_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {INIT, RUN, MDU_BUSY} state_t;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
  localparam int CNT4_W = 4;
endpackage

// File: rtl/hazard_down_counter.sv
// hazard_down_counter: loadable down-counter with zero flag, shared by INIT and MDU_BUSY
// Ports: clk, rst_n (async, active-low); load/load_val reload; dec counts down, stops at 0; zero flags cnt==0
module hazard_down_counter import hazard_pkg::*; #(
  parameter logic [CNT4_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CNT4_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);
  logic [CNT4_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: ID/EX and front-end sequencing for load-use, taken-branch and MDU hazards
// Inputs: clk, rst_n (async, active-low), ID source regs if_id_rs/if_id_rt/if_id_uses_rt,
//   EX load info id_ex_mem_read/id_ex_rt, branch_taken, mdu_start.
// Outputs: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, mdu_busy;
//   stall_cnt/flush_cnt exist only when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl import hazard_pkg::*; #(
  parameter int MDU_LAT  = 4,
  parameter int INIT_CYC = 3,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] if_id_rs,
  input  logic [REG_IDX_W-1:0] if_id_rt,
  input  logic                 if_id_uses_rt,
  input  logic                 id_ex_mem_read,
  input  logic [REG_IDX_W-1:0] id_ex_rt,
  input  logic                 branch_taken,
  input  logic                 mdu_start,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_bubble,
  output logic                 mdu_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);
  if (MDU_LAT < 2 || MDU_LAT > 15 || INIT_CYC < 1 || INIT_CYC > 15 || CNT_W < 1)
    $error("pipeline_hazard_ctrl: parameter out of range");
  state_t state, state_nx;
  logic cnt_load, cnt_zero, load_use;
  assign load_use = id_ex_mem_read && id_ex_rt != ZERO_REG &&
                    (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
  // the MDU start cycle is the first frozen cycle, so MDU_BUSY covers the remaining MDU_LAT-1
  hazard_down_counter #(.RST_VAL(CNT4_W'(INIT_CYC - 1))) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT4_W'(MDU_LAT - 2)),
    .dec      (state != RUN),
    .zero     (cnt_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    pc_write = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_write = 1'b1;
    id_ex_bubble = 1'b0;
    mdu_busy = 1'b0;
    case (state)
      INIT: begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_bubble = 1'b1;
        state_nx = cnt_zero ? RUN : INIT;
      end
      MDU_BUSY: begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        mdu_busy = 1'b1;
        state_nx = cnt_zero ? RUN : MDU_BUSY;
      end
      default: begin
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_bubble = 1'b1;
          state_nx = RUN;
        end else if (mdu_start) begin
          pc_write = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          mdu_busy = 1'b1;
          cnt_load = 1'b1;
          state_nx = MDU_BUSY;
        end else if (load_use) begin
          pc_write = 1'b0;
          if_id_write = 1'b0;
          id_ex_bubble = 1'b1;
          state_nx = RUN;
        end else state_nx = RUN;
      end
    endcase
  end
  // EX holds the MDU op while busy, so a taken branch there is a pipeline bug
  assert property (@(posedge clk) disable iff (!rst_n) state == MDU_BUSY |-> !branch_taken);
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != INIT && !pc_write && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (state == RUN && branch_taken && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with a cycle-count reference model
module tb_pipeline_hazard_ctrl;
  localparam int MDU_LAT = 4;
  localparam int INIT_CYC = 3;
  localparam int CNT_W = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
  logic if_id_uses_rt = 1'b0, id_ex_mem_read = 1'b0, branch_taken = 1'b0, mdu_start = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, mdu_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .INIT_CYC(INIT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .mdu_busy(mdu_busy)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
`ifndef HAZ_PERF_CNT_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
  typedef struct {
    string nm;
    logic [5:0] o;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int init_left = 0, mdu_left = 0;
  bit prev_stall = 0, done = 0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;
  // o = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, mdu_busy}
  task automatic cyc(input string nm, input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                     input bit urt, input bit mr, input logic [4:0] ert, input bit br, input bit ms);
    exp_t e;
    bit in_init;
    @(negedge clk);
    rst_n = rst; if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = urt;
    id_ex_mem_read = mr; id_ex_rt = ert; branch_taken = br; mdu_start = ms;
    e.nm = nm;
    prev_stall = 0;
    in_init = 0;
    if (!rst) begin
      e.o = 6'b001110;
      init_left = INIT_CYC; mdu_left = 0; m_stall = '0; m_flush = '0;
      in_init = 1;
    end else if (init_left > 0) begin
      e.o = 6'b001110; init_left--; in_init = 1;
    end else if (mdu_left > 0) begin
      e.o = 6'b000001; mdu_left--;
    end else if (br) begin
      e.o = 6'b111110;
    end else if (ms) begin
      e.o = 6'b000001; mdu_left = MDU_LAT - 1;
    end else if (mr && ert != 0 && (ert == rs || (urt && ert == rt))) begin
      e.o = 6'b000110; prev_stall = 1;
    end else e.o = 6'b110100;
    e.sc = m_stall;
    e.fc = m_flush;
`ifndef HAZ_PERF_CNT_EN
    e.sc = '0;
    e.fc = '0;
`endif
    if (rst && !in_init) begin
      if (!e.o[5] && m_stall != '1) m_stall++;
      if (br && e.o == 6'b111110 && m_flush != '1) m_flush++;
    end
    q.push_back(e);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        logic [5:0] act;
        e = q.pop_front();
        act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, mdu_busy};
        checks++;
        if (act !== e.o || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          errors++;
          $display("FAIL %s: got o=%b sc=%0d fc=%0d, want o=%b sc=%0d fc=%0d",
                   e.nm, act, stall_cnt, flush_cnt, e.o, e.sc, e.fc);
        end
      end
    end
  end
  initial begin
    cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst1", 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < INIT_CYC; i++) cyc("init", 1, 8, 8, 1, 1, 8, 1, 1);
    cyc("run_first", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("lu_rs", 1, 8, 0, 0, 1, 8, 0, 0);
    cyc("lu_after", 1, 8, 0, 0, 0, 8, 0, 0);
    cyc("lu_zero", 1, 0, 0, 1, 1, 0, 0, 0);
    cyc("lu_rt_unused", 1, 3, 8, 0, 1, 8, 0, 0);
    cyc("lu_rt_used", 1, 3, 8, 1, 1, 8, 0, 0);
    cyc("lu_rt_after", 1, 3, 8, 1, 0, 8, 0, 0);
    cyc("mdu_start", 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i < MDU_LAT; i++) cyc("mdu_busy_lu", 1, 8, 0, 0, 1, 8, 0, 0);
    cyc("mdu_done", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("br_mdu", 1, 0, 0, 0, 0, 0, 1, 1);
    cyc("br_after", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("mdu2_start", 1, 0, 0, 0, 0, 0, 0, 1);
    cyc("mdu2_busy1", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("mdu2_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < INIT_CYC; i++) cyc("reinit", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("rerun", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit rst, br, ms, mr;
      rst = $urandom_range(0, 199) != 0;
      br = $urandom_range(0, 7) == 0 && mdu_left == 0;
      ms = $urandom_range(0, 9) == 0;
      mr = $urandom_range(0, 1) == 1 && !prev_stall;
      cyc("rand", rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          mr, 5'($urandom_range(0, 3)), br, ms);
    end
    done = 1;
  end
  initial begin
    wait (done);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: got no completion, want done");
    $fatal(1, "timeout");
  end
endmodule
